// File: rtl/nx1_wb_cmd_master_pkg.sv
// nx1_pkg: shared constants and helpers for the NX1 Wishbone command master.
//   - command mode encodings, response error codes, FSM states
//   - macro command address and packed-command field widths
//   - pack_cmd(): {mode, row, col, data} -> 32-bit bus word
package nx1_pkg;
  localparam logic [1:0] MODE_PROGRAM = 2'b11;
  localparam logic [1:0] MODE_READ    = 2'b01;
  localparam logic [1:0] MODE_FETCH   = 2'b00;

  typedef enum logic [1:0] {
    ERR_OK  = 2'b00,
    ERR_OP  = 2'b01,
    ERR_CNT = 2'b10,
    ERR_TMO = 2'b11
  } err_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RSP  = 2'd2
  } state_t;

  localparam logic [31:0] ADDR_MATCH = 32'h3000_000C;

  localparam int ROW_W  = 5;
  localparam int COL_W  = 5;
  localparam int DATA_W = 20;

  function automatic logic [31:0] pack_cmd(input logic [1:0]        mode,
                                           input logic [ROW_W-1:0]  row,
                                           input logic [COL_W-1:0]  col,
                                           input logic [DATA_W-1:0] data);
    return {mode, row, col, data};
  endfunction
endpackage

// File: rtl/nx1_wb_cmd_master_if.sv
// nx1_wb_cmd_master_if: command stream, response stream and Wishbone master
// signals of nx1_wb_cmd_master.
//   master modport: the command master's view (drives cmd_ready, rsp_*,
//                   outstanding, wbm_*_o)
//   slave modport : the environment's view (drives cmd_*, rsp_ready,
//                   wbm_dat_i, wbm_ack_i)
interface nx1_wb_cmd_master_if #(
  parameter int RD_DEPTH = 32
) ();
  import nx1_pkg::*;

  localparam int CNT_W = $clog2(RD_DEPTH + 1);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ROW_W-1:0]  cmd_row;
  logic [COL_W-1:0]  cmd_col;
  logic [DATA_W-1:0] cmd_data;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic [1:0]        rsp_err;
  logic [CNT_W-1:0]  outstanding;

  logic              wbm_cyc_o;
  logic              wbm_stb_o;
  logic              wbm_we_o;
  logic [3:0]        wbm_sel_o;
  logic [31:0]       wbm_adr_o;
  logic [31:0]       wbm_dat_o;
  logic [31:0]       wbm_dat_i;
  logic              wbm_ack_i;

  modport master (
    input  cmd_valid, cmd_op, cmd_row, cmd_col, cmd_data, rsp_ready,
           wbm_dat_i, wbm_ack_i,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, outstanding,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_row, cmd_col, cmd_data, rsp_ready,
           wbm_dat_i, wbm_ack_i,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, outstanding,
           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
  );
endinterface

// File: rtl/nx1_wb_cmd_master_rd_credit.sv
// nx1_rd_credit: up/down count of read-issue commands whose result has not
// yet been fetched from the macro's result FIFO.
//   i_clk, i_rst : clock, async active-high reset
//   i_inc, i_dec : one-cycle strobes (acked READ_ISSUE / acked FETCH)
//   o_count      : current count, 0..DEPTH
//   o_full       : count == DEPTH
//   o_empty      : count == 0
module nx1_rd_credit #(
  parameter int DEPTH = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);
  logic [CNT_W-1:0] r_count;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // saturating guards are belt-and-braces; the master never strobes past
  // the limits
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                    r_count <= '0;
    else if (i_inc && !o_full)    r_count <= r_count + 1'b1;
    else if (i_dec && !o_empty)   r_count <= r_count - 1'b1;
  end
endmodule

// File: rtl/nx1_wb_cmd_master.sv
// nx1_wb_cmd_master: turns a valid/ready command stream into single 32-bit
// Wishbone cycles at BASE_ADDR for the Neuromorphic_X1 macro and returns
// exactly one response per accepted command.
//   wb_clk_i : sole clock
//   wb_rst_i : async active-high reset
//   bus      : nx1_wb_cmd_master_if.master (cmd_*, rsp_*, outstanding, wbm_*)
// Build option: define NX1_WBM_TIMEOUT_EN to abort a bus cycle that sees no
// ack within TIMEOUT_CYCLES edges (response error 11).
module nx1_wb_cmd_master
  import nx1_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_000C,
  parameter int          RD_DEPTH       = 32,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  nx1_wb_cmd_master_if.master  bus
);
  state_t      r_state, w_state_nxt;
  logic        r_cyc, r_we;
  logic [31:0] r_dat;
  logic [1:0]  r_op;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;
  err_t        r_rsp_err;

  logic        w_accept, w_ack, w_tmo, w_go_bus, w_we_nxt;
  logic [31:0] w_dat_nxt;
  err_t        w_err_nxt;
  logic        w_full, w_empty;

  assign w_accept = bus.cmd_valid && (r_state == S_IDLE);
  assign w_ack    = (r_state == S_BUS) && bus.wbm_ack_i;

`ifdef NX1_WBM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;

  // r_to_cnt counts BUS edges since assertion; the TIMEOUT_CYCLES-th edge
  // without ack drops the cycle
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)                r_to_cnt <= '0;
    else if (w_go_bus)           r_to_cnt <= '0;
    else if (r_state == S_BUS)   r_to_cnt <= r_to_cnt + 1'b1;
  end

  assign w_tmo = (r_state == S_BUS) && !bus.wbm_ack_i &&
                 (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] w_unused_tmo_cfg;
  assign w_unused_tmo_cfg = TIMEOUT_CYCLES;
  assign w_tmo = 1'b0;
`endif

  nx1_rd_credit #(.DEPTH(RD_DEPTH)) u_credit (
    .i_clk   (wb_clk_i),
    .i_rst   (wb_rst_i),
    .i_inc   (w_ack && (r_op == MODE_READ)),
    .i_dec   (w_ack && (r_op == MODE_FETCH)),
    .o_count (bus.outstanding),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_go_bus    = 1'b0;
    w_we_nxt    = 1'b0;
    w_dat_nxt   = '0;
    w_err_nxt   = ERR_OK;
    unique case (r_state)
      S_IDLE: if (w_accept) begin
        unique case (bus.cmd_op)
          MODE_PROGRAM: begin
            w_go_bus  = 1'b1;
            w_we_nxt  = 1'b1;
            w_dat_nxt = pack_cmd(MODE_PROGRAM, bus.cmd_row, bus.cmd_col, bus.cmd_data);
          end
          MODE_READ: begin
            if (w_full) w_err_nxt = ERR_CNT;
            else begin
              w_go_bus  = 1'b1;
              w_we_nxt  = 1'b1;
              w_dat_nxt = pack_cmd(MODE_READ, bus.cmd_row, bus.cmd_col, '0);
            end
          end
          MODE_FETCH: begin
            if (w_empty) w_err_nxt = ERR_CNT;
            else         w_go_bus  = 1'b1;
          end
          default: w_err_nxt = ERR_OP;
        endcase
        w_state_nxt = w_go_bus ? S_BUS : S_RSP;
      end
      S_BUS:   if (w_ack || w_tmo) w_state_nxt = S_RSP;
      S_RSP:   if (bus.rsp_ready)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // bus registers: loaded on accept, held until ack (or timeout)
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_cyc <= 1'b0;
      r_we  <= 1'b0;
      r_dat <= '0;
      r_op  <= MODE_FETCH;
    end else if (w_go_bus) begin
      r_cyc <= 1'b1;
      r_we  <= w_we_nxt;
      r_dat <= w_dat_nxt;
      r_op  <= bus.cmd_op;
    end else if (w_ack || w_tmo) begin
      r_cyc <= 1'b0;
      r_we  <= 1'b0;
      r_dat <= '0;
    end
  end

  // response registers: rejected commands respond straight from IDLE
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= ERR_OK;
    end else if (w_accept && !w_go_bus) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= '0;
      r_rsp_err   <= w_err_nxt;
    end else if (w_ack) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= (r_op == MODE_FETCH) ? bus.wbm_dat_i : '0;
      r_rsp_err   <= ERR_OK;
    end else if (w_tmo) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= '0;
      r_rsp_err   <= ERR_TMO;
    end else if ((r_state == S_RSP) && bus.rsp_ready) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= ERR_OK;
    end
  end

  assign bus.cmd_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;

  assign bus.wbm_cyc_o = r_cyc;
  assign bus.wbm_stb_o = r_cyc;
  assign bus.wbm_we_o  = r_we;
  assign bus.wbm_sel_o = r_cyc ? 4'hF : 4'h0;
  assign bus.wbm_adr_o = r_cyc ? BASE_ADDR : 32'h0;
  assign bus.wbm_dat_o = r_dat;
endmodule

// File: tb/tb_nx1_wb_cmd_master.sv
// tb_nx1_wb_cmd_master: directed bench with a response scoreboard for
// nx1_wb_cmd_master. Honours NX1_WBM_TIMEOUT_EN (timeout set to 16 cycles).
module tb_nx1_wb_cmd_master;
  import nx1_pkg::*;

  localparam int RD_DEPTH = 32;
  localparam int TMO      = 16;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nx1_wb_cmd_master_if #(.RD_DEPTH(RD_DEPTH)) bus ();

  nx1_wb_cmd_master #(
    .BASE_ADDR      (32'h3000_000C),
    .RD_DEPTH       (RD_DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  rsp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          m_out = 0;
  logic        exp_we;
  logic [31:0] exp_dat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // drive one command for one accept edge; push the expected response
  task automatic send(input logic [1:0] op, input logic [4:0] row, input logic [4:0] col,
                      input logic [19:0] data, input logic [31:0] rdat, input bit tmo);
    rsp_t r;
    r.data = '0;
    r.err  = 2'b00;
    if (op == 2'b10)                          r.err = 2'b01;
    else if (op == 2'b01 && m_out == RD_DEPTH) r.err = 2'b10;
    else if (op == 2'b00 && m_out == 0)        r.err = 2'b10;
    else if (tmo)                              r.err = 2'b11;
    if (r.err == 2'b00) begin
      if (op == 2'b01) m_out++;
      if (op == 2'b00) begin m_out--; r.data = rdat; end
    end
    exp_we  = op[0];
    exp_dat = (op == 2'b11) ? {op, row, col, data} :
              (op == 2'b01) ? {op, row, col, 20'h0} : 32'h0;
    sb.push_back(r);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_row   = row;
    bus.cmd_col   = col;
    bus.cmd_data  = data;
    chk("cmd_ready", bus.cmd_ready, 1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  // Wishbone slave: check the cycle for dly+1 cycles, then ack once
  task automatic slave(input int dly, input logic [31:0] rdat, input string tag);
    int n = 0;
    @(negedge clk);
    while (!bus.wbm_cyc_o && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_cyc"}, bus.wbm_cyc_o, 1);
    for (int i = 0; i <= dly; i++) begin
      if (i > 0) @(negedge clk);
      chk({tag, "_stb"}, bus.wbm_stb_o, 1);
      chk({tag, "_we"},  bus.wbm_we_o,  exp_we);
      chk({tag, "_sel"}, bus.wbm_sel_o, 4'hF);
      chk({tag, "_adr"}, bus.wbm_adr_o, 32'h3000_000C);
      chk({tag, "_dat"}, bus.wbm_dat_o, exp_dat);
    end
    bus.wbm_dat_i = rdat;
    bus.wbm_ack_i = 1'b1;
    @(posedge clk);
    #1 bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = '0;
    @(negedge clk);
    chk({tag, "_cyc_rel"}, bus.wbm_cyc_o, 0);
    chk({tag, "_adr_rel"}, bus.wbm_adr_o, 0);
  endtask

  // response sink: called at a negedge; optionally stalls rsp_ready
  task automatic recv(input int hold, input string tag);
    rsp_t e;
    int   n = 0;
    while (!bus.rsp_valid && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 1);
    if (sb.size() == 0) begin
      tests++; fails++;
      $error("FAIL %s_sb: observed response with no expected entry", tag);
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_valid"}, bus.rsp_valid, 1);
      chk({tag, "_hold_err"},   bus.rsp_err,   e.err);
      chk({tag, "_hold_rdy"},   bus.cmd_ready, 0);
      chk({tag, "_hold_cyc"},   bus.wbm_cyc_o, 0);
      @(negedge clk);
    end
    chk({tag, "_rsp_data"}, bus.rsp_data, e.data);
    chk({tag, "_rsp_err"},  bus.rsp_err,  e.err);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_rsp_clr"},  bus.rsp_valid, 0);
    chk({tag, "_rdy_back"}, bus.cmd_ready, 1);
  endtask

  initial begin
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_row   = '0;
    bus.cmd_col   = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    bus.wbm_dat_i = '0;
    bus.wbm_ack_i = 1'b0;

    // reset state
    #2;
    chk("rst_cyc", bus.wbm_cyc_o, 0);
    chk("rst_stb", bus.wbm_stb_o, 0);
    chk("rst_we",  bus.wbm_we_o,  0);
    chk("rst_sel", bus.wbm_sel_o, 0);
    chk("rst_adr", bus.wbm_adr_o, 0);
    chk("rst_dat", bus.wbm_dat_o, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data",  bus.rsp_data,  0);
    chk("rst_rsp_err",   bus.rsp_err,   0);
    chk("rst_out",       bus.outstanding, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1);

    // PROGRAM, zero-wait ack
    send(2'b11, 5'd1, 5'd1, 20'h000FF, 32'h0, 1'b0);
    chk("prog_word", exp_dat, 32'hC210_00FF);
    slave(0, 32'hDEAD_BEEF, "prog");
    recv(0, "prog");
    chk("prog_out", bus.outstanding, 0);

    // READ_ISSUE then FETCH
    send(2'b01, 5'd5, 5'd4, 20'h0, 32'h0, 1'b0);
    slave(0, 32'h0, "rdi");
    recv(0, "rdi");
    chk("rdi_out", bus.outstanding, 1);
    send(2'b00, 5'd5, 5'd4, 20'h0, 32'h1, 1'b0);
    slave(0, 32'h1, "fetch");
    recv(0, "fetch");
    chk("fetch_out", bus.outstanding, 0);

    // FETCH with nothing outstanding
    send(2'b00, 5'd0, 5'd0, 20'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("under_nocyc", bus.wbm_cyc_o, 0);
    recv(0, "under");

    // fill the read credit, then overflow
    for (int k = 0; k < RD_DEPTH; k++) begin
      send(2'b01, 5'(k), 5'(31 - k), 20'h0, 32'h0, 1'b0);
      slave(0, 32'h0, "fill");
      recv(0, "fill");
    end
    chk("full_out", bus.outstanding, RD_DEPTH);
    send(2'b01, 5'd3, 5'd3, 20'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("over_nocyc", bus.wbm_cyc_o, 0);
    recv(0, "over");
    chk("over_out", bus.outstanding, RD_DEPTH);

    // FETCH with a 7-cycle ack delay
    send(2'b00, 5'd2, 5'd9, 20'h0, 32'hA5A5_0001, 1'b0);
    slave(7, 32'hA5A5_0001, "slow");
    recv(0, "slow");
    chk("slow_out", bus.outstanding, RD_DEPTH - 1);

    // reserved op, response held off for 5 cycles
    send(2'b10, 5'd7, 5'd7, 20'hFFFFF, 32'h0, 1'b0);
    @(negedge clk);
    chk("rsv_nocyc", bus.wbm_cyc_o, 0);
    recv(5, "rsv");

    // reset in the middle of a bus cycle
    send(2'b01, 5'd1, 5'd2, 20'h0, 32'h0, 1'b0);
    @(negedge clk); @(negedge clk);
    chk("mid_cyc", bus.wbm_cyc_o, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_cyc", bus.wbm_cyc_o, 0);
    chk("mid_rst_stb", bus.wbm_stb_o, 0);
    chk("mid_rst_out", bus.outstanding, 0);
    sb.delete();
    m_out = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rsp_valid", bus.rsp_valid, 0);
    chk("mid_cmd_ready", bus.cmd_ready, 1);

    // stalled slave: one credit outstanding, FETCH never acked
    send(2'b01, 5'd4, 5'd4, 20'h0, 32'h0, 1'b0);
    slave(0, 32'h0, "pre");
    recv(0, "pre");
`ifdef NX1_WBM_TIMEOUT_EN
    send(2'b00, 5'd4, 5'd4, 20'h0, 32'h0, 1'b1);
`else
    send(2'b00, 5'd4, 5'd4, 20'h0, 32'h0, 1'b0);
`endif
    n = 0;
    @(negedge clk);
    while (bus.wbm_cyc_o && n < 200) begin n++; @(negedge clk); end
`ifdef NX1_WBM_TIMEOUT_EN
    chk("tmo_cycles", n, TMO);
    recv(0, "tmo");
    chk("tmo_out", bus.outstanding, 1);
`else
    chk("hang_cycles", n, 200);
    chk("hang_cyc", bus.wbm_cyc_o, 1);
    rst = 1'b1;
    #1;
    chk("hang_rst_cyc", bus.wbm_cyc_o, 0);
    sb.delete();
    m_out = 0;
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/nx1_wb_cmd_master.md
Name: nx1_wb_cmd_master

Overview:
- Single-clock Wishbone master sitting directly upstream of the Neuromorphic_X1_wb slave.
- Converts a valid/ready command stream (program, read-issue, fetch) into 32-bit Wishbone cycles at the macro's command address.
- Packs each command as {mode[1:0], row[4:0], col[4:0], data[19:0]}.
- Tracks outstanding read results against the macro's result-FIFO depth and returns exactly one response per accepted command.

Parameters:
- BASE_ADDR, 32'h3000_000C, Wishbone address used for every cycle.
- RD_DEPTH, 32, maximum read-issue commands awaiting fetch.
- TIMEOUT_CYCLES, 1024, ack wait limit in cycles (used only with NX1_WBM_TIMEOUT_EN).

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&ready
- cmd_op  in  2  11=PROGRAM, 01=READ_ISSUE, 00=FETCH, 10=reserved
- cmd_row  in  5  array row
- cmd_col  in  5  array column
- cmd_data  in  20  program data (ignored for READ_ISSUE/FETCH)
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when valid&ready
- rsp_data  out  32  fetched word (FETCH); 0 otherwise
- rsp_err  out  2  00 ok, 01 illegal op, 10 count over/underflow, 11 ack timeout
- outstanding  out  clog2(RD_DEPTH+1)  issued-but-unfetched reads
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  bus control
- wbm_sel_o  out  4  always 4'hF during a cycle, 0 otherwise
- wbm_adr_o  out  32  BASE_ADDR during a cycle, 0 otherwise
- wbm_dat_o  out  32  packed command during writes, 0 otherwise
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  slave acknowledge

Behaviour:
- Reset values: all wbm_* outputs 0; rsp_valid 0; rsp_data 0; rsp_err 0; outstanding 0; FSM in IDLE; cmd_ready 1 after reset deasserts.
- Reset mid-cycle drops cyc/stb immediately (asynchronous) and discards any pending response.
- FSM has three states: IDLE, BUS, RSP.
- cmd_ready = (state==IDLE), combinational from the state register.
- IDLE, on accept:
  - PROGRAM → BUS, we=1, dat={2'b11,row,col,data}.
  - READ_ISSUE → BUS, we=1, dat={2'b01,row,col,20'h0}. If outstanding==RD_DEPTH: no bus cycle, → RSP, err=10.
  - FETCH → BUS, we=0. If outstanding==0: no bus cycle, → RSP, err=10.
  - op 10 → RSP, err=01, no bus cycle.
- Bus signals are registered. cyc/stb/we/sel/adr/dat go high on the edge after accept and stay stable until ack.
- ack_i is sampled only in BUS. On the edge where ack_i=1:
  - all wbm_* return to 0;
  - rsp_valid rises;
  - FETCH latches rsp_data=wbm_dat_i;
  - state → RSP.
- Counter updates happen on the ack edge: READ_ISSUE +1, FETCH -1. The counter never changes outside an acked cycle.
- RSP holds rsp_valid/data/err stable until rsp_ready; the handshake edge clears rsp_valid → IDLE.
- Minimum command-to-command spacing: 3 cycles (accept, bus, ack+1, then rsp handshake in RSP).
- Exactly one response per accepted command; no pipelining; one bus cycle at most in flight.

Optional Feature:
- Macro: NX1_WBM_TIMEOUT_EN.
- Defined: a counter starts at bus assertion. If TIMEOUT_CYCLES edges pass in BUS without ack, the cycle drops, rsp_err=11, rsp_data=0, outstanding is unchanged, and state → RSP. A late ack after the drop is ignored.
- Undefined: no counter logic; BUS waits indefinitely for ack; error code 11 is never produced.

Decomposition:
- Shared package nx1_pkg holds:
  - mode constants MODE_PROGRAM=2'b11, MODE_READ=2'b01, MODE_FETCH=2'b00;
  - error codes;
  - ADDR_MATCH=32'h3000_000C;
  - row/col/data field widths;
  - a pack_cmd function.
- One natural sub-module: nx1_rd_credit (up/down outstanding counter with full/empty flags).

Test Plan:
- PROGRAM row=1 col=1 data=20'h0FF with zero-wait slave ack → wbm_dat_o=32'hC21000FF, we=1, adr=32'h3000_000C; rsp err=00, data=0; outstanding stays 0.
- READ_ISSUE row=5 col=4, then FETCH with slave returning 32'h1 → outstanding goes 1 then 0; FETCH rsp_data=32'h1, err=00, we=0 during the read.
- 32 READ_ISSUE commands then a 33rd → outstanding=32; 33rd gets err=10 with no cyc pulse. FETCH with outstanding=0 → err=10, no cyc.
- cmd_op=10 → err=01, no bus activity. Hold rsp_ready low 5 cycles → rsp_valid and rsp_err stable, cmd_ready=0 throughout.
- Slave ack delayed 7 cycles → cyc/stb/adr/dat stable for all 7 cycles, released on the edge after ack. Assert wb_rst_i mid-cycle → cyc/stb=0 immediately and outstanding=0.
- With NX1_WBM_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never acks → cycle drops after 16 cycles with err=11 and outstanding unchanged. Without the macro → cyc stays high for 100+ cycles.
